// File: rtl/eth_tx_framer.sv
// Byte-rate Ethernet transmit framer feeding the RMII dibit serializer.
// Wraps a valid/ready payload stream with preamble, SFD, zero pad and FCS,
// then holds the line idle for the inter-frame gap.
//
// state | meaning
// IDLE  | waiting for tx_valid; nothing consumed yet
// PRE   | emitting PREAMBLE_LEN bytes of 0x55
// SFD   | emitting 0xD5; CRC and byte count restart here
// DATA  | forwarding payload bytes through the CRC
// PAD   | emitting 0x00 until MIN_FRAME bytes have gone out
// FCS   | emitting the inverted CRC, least-significant byte first
// DRAIN | payload starved mid-frame; swallow input up to tx_last
// IFG   | IFG_BYTES idle byte times before the next frame
`timescale 1ns/1ps
module eth_tx_framer #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int PAD_EN       = 1,
   parameter int IFG_BYTES    = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] phy_tx_data,
   output logic       phy_tx_valid,
   output logic       frame_done,
   output logic       tx_underrun
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_SFD   = 3'd2,
      S_DATA  = 3'd3,
      S_PAD   = 3'd4,
      S_FCS   = 3'd5,
      S_DRAIN = 3'd6,
      S_IFG   = 3'd7
   } state_t;

   localparam logic [7:0]  PRE_LOAD = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]  IFG_LOAD = 8'(IFG_BYTES - 1);
   localparam logic [7:0]  FCS_LOAD = 8'd3;
   localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);

   state_t      state;
   logic [7:0]  tmr;
   logic [15:0] byte_cnt;
   logic [31:0] crc;

   logic        tmr_tc;
   logic [15:0] cnt_inc;
   logic [31:0] crc_data;
   logic [31:0] crc_pad;
   logic [7:0]  fcs_byte;

   // One byte of reflected CRC-32, bit 0 of the byte first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h000000, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   // Next-state helpers: saturating byte count, CRC candidates, FCS byte select.
   always_comb begin
      tmr_tc   = (tmr == 8'd0);
      cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
      crc_data = crc_byte(crc, tx_data);
      crc_pad  = crc_byte(crc, 8'h00);
      fcs_byte = 8'h00;
      case (tmr[1:0])
         2'd3:    fcs_byte = ~crc[7:0];
         2'd2:    fcs_byte = ~crc[15:8];
         2'd1:    fcs_byte = ~crc[23:16];
         default: fcs_byte = ~crc[31:24];
      endcase
   end

   assign tx_ready = (state == S_DATA) || (state == S_DRAIN);

   // Framing FSM; every PHY-side output is loaded here and defaults to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         tmr          <= 8'd0;
         byte_cnt     <= 16'd0;
         crc          <= 32'hFFFFFFFF;
         phy_tx_data  <= 8'h00;
         phy_tx_valid <= 1'b0;
         frame_done   <= 1'b0;
         tx_underrun  <= 1'b0;
      end else begin
         phy_tx_data  <= 8'h00;
         phy_tx_valid <= 1'b0;
         frame_done   <= 1'b0;
         tx_underrun  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tx_valid) begin
                  state <= S_PRE;
                  tmr   <= PRE_LOAD;
               end
            end
            S_PRE: begin
               phy_tx_data  <= 8'h55;
               phy_tx_valid <= 1'b1;
               if (tmr_tc) state <= S_SFD;
               else        tmr   <= tmr - 8'd1;
            end
            S_SFD: begin
               phy_tx_data  <= 8'hD5;
               phy_tx_valid <= 1'b1;
               crc          <= 32'hFFFFFFFF;
               byte_cnt     <= 16'd0;
               state        <= S_DATA;
            end
            S_DATA: begin
               if (tx_valid) begin
                  phy_tx_data  <= tx_data;
                  phy_tx_valid <= 1'b1;
                  crc          <= crc_data;
                  byte_cnt     <= cnt_inc;
                  if (tx_last) begin
                     if ((PAD_EN != 0) && (cnt_inc < MIN_CNT)) begin
                        state <= S_PAD;
                     end else begin
                        state <= S_FCS;
                        tmr   <= FCS_LOAD;
                     end
                  end
               end else begin
                  // Starved: the line must drop now, the frame is abandoned.
                  tx_underrun <= 1'b1;
                  state       <= S_DRAIN;
               end
            end
            S_PAD: begin
               phy_tx_valid <= 1'b1;
               crc          <= crc_pad;
               byte_cnt     <= cnt_inc;
               if (cnt_inc >= MIN_CNT) begin
                  state <= S_FCS;
                  tmr   <= FCS_LOAD;
               end
            end
            S_FCS: begin
               phy_tx_data  <= fcs_byte;
               phy_tx_valid <= 1'b1;
               if (tmr_tc) begin
                  frame_done <= 1'b1;
                  state      <= S_IFG;
                  tmr        <= IFG_LOAD;
               end else begin
                  tmr <= tmr - 8'd1;
               end
            end
            S_DRAIN: begin
               if (tx_valid && tx_last) begin
                  state <= S_IFG;
                  tmr   <= IFG_LOAD;
               end
            end
            S_IFG: begin
               if (tmr_tc) state <= S_IDLE;
               else        tmr   <= tmr - 8'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: two instances (padding off / on) share one stimulus
// port; a frame-level model predicts the PHY byte stream cycle by cycle.
`timescale 1ns/1ps
module tb_eth_tx_framer;

   localparam int PRE_LEN = 7;
   localparam int MIN_LEN = 60;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       act;

   logic       rdy0, rdy1, v0, v1, done0, done1, unr0, unr1;
   logic [7:0] d0, d1;
   logic       rdy, phy_v, done, unr;
   logic [7:0] phy_d;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 0;

   eth_tx_framer #(.PAD_EN(0)) u_nopad (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid & ~act),
      .tx_last      (tx_last),
      .tx_ready     (rdy0),
      .phy_tx_data  (d0),
      .phy_tx_valid (v0),
      .frame_done   (done0),
      .tx_underrun  (unr0)
   );

   eth_tx_framer #(.PAD_EN(1)) u_pad (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid & act),
      .tx_last      (tx_last),
      .tx_ready     (rdy1),
      .phy_tx_data  (d1),
      .phy_tx_valid (v1),
      .frame_done   (done1),
      .tx_underrun  (unr1)
   );

   assign rdy   = act ? rdy1  : rdy0;
   assign phy_v = act ? v1    : v0;
   assign phy_d = act ? d1    : d0;
   assign done  = act ? done1 : done0;
   assign unr   = act ? unr1  : unr0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Model: reflected CRC-32 via a 256-entry table.
   logic [31:0] crc_tab [256];
   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [31:0] r;
         r = 32'(i);
         for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
         crc_tab[i] = r;
      end
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] r, input logic [7:0] d);
      return (r >> 8) ^ crc_tab[r[7:0] ^ d];
   endfunction

   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic       done;
      logic       unr;
      logic       chk_rdy;
   } exp_t;

   exp_t       exp_q[$];
   int         lens[$];
   logic [7:0] cur[$];
   logic [7:0] last_frame[$];

   function automatic void push(input logic v, input logic [7:0] d, input logic dn,
                                input logic un, input logic cr);
      exp_t e;
      e.v = v; e.d = d; e.done = dn; e.unr = un; e.chk_rdy = cr;
      exp_q.push_back(e);
   endfunction

   // Expected PHY stream of one frame; hole_at >= 0 means underrun after that many bytes.
   task automatic push_frame(input logic [7:0] p[$], input bit pad_en, input int pre_idle,
                             input int hole_at);
      logic [7:0]  body[$];
      logic [31:0] r;
      repeat (pre_idle) push(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      push(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      repeat (PRE_LEN) push(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      push(1'b1, 8'hD5, 1'b0, 1'b0, 1'b0);
      if (hole_at >= 0) begin
         for (int i = 0; i < hole_at; i++) push(1'b1, p[i], 1'b0, 1'b0, 1'b0);
         push(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         return;
      end
      body = p;
      if (pad_en) while (body.size() < MIN_LEN) body.push_back(8'h00);
      r = 32'hFFFFFFFF;
      foreach (body[i]) r = crc_upd(r, body[i]);
      r = ~r;
      foreach (body[i]) push(1'b1, body[i], 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) push(1'b1, r[8*k +: 8], (k == 3), 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, expv);
      end
   endtask

   // Per-cycle comparison of the active instance against the model stream.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         e = '0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         checks++;
         if (phy_v !== e.v || phy_d !== e.d || done !== e.done || unr !== e.unr ||
             (e.chk_rdy && rdy !== 1'b0)) begin
            errors++;
            $display("FAIL stream cyc=%0d got v=%b d=%h done=%b unr=%b rdy=%b exp v=%b d=%h done=%b unr=%b",
                     cyc, phy_v, phy_d, done, unr, rdy, e.v, e.d, e.done, e.unr);
         end
      end
   end

   // Capture each contiguous run of phy_tx_valid as one frame.
   always @(negedge clk) begin
      if (phy_v) begin
         cur.push_back(phy_d);
      end else if (cur.size() > 0) begin
         lens.push_back(cur.size());
         last_frame = cur;
         cur.delete();
      end
   end

   // Drive a payload honouring tx_ready; optional one-cycle hole, mid-frame reset, hold-valid.
   task automatic send_frame(input logic [7:0] p[$], input bit pad_en, input int pre_idle,
                             input int hole_at, input int rst_at, input bit keep);
      int idx;
      bit acc;
      bit holed;
      int budget;
      push_frame(p, pad_en, pre_idle, hole_at);
      idx = 0; holed = 0; budget = 0;
      tx_valid = 1'b1; tx_data = p[0]; tx_last = (p.size() == 1); acc = rdy;
      while (idx < p.size()) begin
         @(negedge clk); #1;
         budget++;
         if (budget > 2000) begin
            chk("send timeout", 32'(idx), 32'(p.size()));
            break;
         end
         if (acc) idx++;
         if (idx == p.size()) break;
         if (hole_at >= 0 && idx == hole_at && !holed) begin
            holed = 1; tx_valid = 1'b0; acc = 1'b0;
            continue;
         end
         tx_valid = 1'b1; tx_data = p[idx]; tx_last = (idx == p.size() - 1); acc = rdy;
         if (idx == rst_at) begin
            #2;
            chk_en = 0;
            rst_n = 1'b0;
            #1;
            chk("reset phy_tx_valid", 32'(phy_v), 32'd0);
            chk("reset tx_ready", 32'(rdy), 32'd0);
            chk("reset phy_tx_data", 32'(phy_d), 32'd0);
            tx_valid = 1'b0; tx_last = 1'b0;
            exp_q.delete();
            return;
         end
      end
      if (!keep) begin
         tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
      end
   endtask

   function automatic int count_zero(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++) if (last_frame[i] === 8'h00) n++;
      return n;
   endfunction

   initial begin
      logic [7:0]  p[$];
      logic [7:0]  q[$];
      logic [31:0] r;
      act = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00; rst_n = 1'b0;
      #12;
      chk("rst phy_tx_data", 32'(phy_d), 32'd0);
      chk("rst phy_tx_valid", 32'(phy_v), 32'd0);
      chk("rst tx_ready", 32'(rdy), 32'd0);
      chk("rst frame_done", 32'(done), 32'd0);
      chk("rst tx_underrun", 32'(unr), 32'd0);
      chk("rst pad inst valid", 32'(v1), 32'd0);
      @(negedge clk); #1;
      rst_n = 1'b1; chk_en = 1;
      repeat (3) @(negedge clk);
      #1;

      // "123456789" without padding
      p = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      lens.delete();
      send_frame(p, 1'b0, 0, -1, -1, 1'b0);
      repeat (30) @(negedge clk);
      #1;
      chk("nopad frame count", 32'(lens.size()), 32'd1);
      chk("nopad valid run", 32'(lens[0]), 32'd21);
      chk("nopad first payload", 32'(last_frame[8]), 32'h31);
      chk("nopad fcs0", 32'(last_frame[17]), 32'h26);
      chk("nopad fcs1", 32'(last_frame[18]), 32'h39);
      chk("nopad fcs2", 32'(last_frame[19]), 32'hF4);
      chk("nopad fcs3", 32'(last_frame[20]), 32'hCB);

      // 14-byte payload, padded
      act = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      p.delete();
      for (int i = 0; i < 14; i++) p.push_back(8'(8'h10 + i));
      lens.delete();
      send_frame(p, 1'b1, 0, -1, -1, 1'b0);
      repeat (80) @(negedge clk);
      #1;
      chk("pad14 valid run", 32'(lens[0]), 32'd72);
      chk("pad14 zero bytes", 32'(count_zero(22, 67)), 32'd46);
      r = 32'hFFFFFFFF;
      for (int i = 8; i < 72; i++) r = crc_upd(r, last_frame[i]);
      chk("pad14 crc residue", r, 32'hDEBB20E3);

      // 100-byte payload followed immediately by a 5-byte frame, valid held through IFG
      p.delete();
      for (int i = 0; i < 100; i++) p.push_back(8'(i * 3 + 1));
      q.delete();
      for (int i = 0; i < 5; i++) q.push_back(8'(8'hC0 + i));
      lens.delete();
      send_frame(p, 1'b1, 0, -1, -1, 1'b1);
      send_frame(q, 1'b1, 12, -1, -1, 1'b0);
      repeat (80) @(negedge clk);
      #1;
      chk("b2b frame count", 32'(lens.size()), 32'd2);
      chk("b2b first run", 32'(lens[0]), 32'd112);
      chk("b2b second run", 32'(lens[1]), 32'd72);

      // underrun after payload byte 20, then a clean frame
      p.delete();
      for (int i = 0; i < 40; i++) p.push_back(8'(8'hA0 ^ i));
      lens.delete();
      send_frame(p, 1'b1, 0, 20, -1, 1'b0);
      repeat (30) @(negedge clk);
      #1;
      chk("underrun valid run", 32'(lens[0]), 32'd28);
      p.delete();
      for (int i = 0; i < 16; i++) p.push_back(8'(8'h5A + i));
      lens.delete();
      send_frame(p, 1'b1, 0, -1, -1, 1'b0);
      repeat (80) @(negedge clk);
      #1;
      chk("post-underrun run", 32'(lens[0]), 32'd72);

      // asynchronous reset during payload byte 30
      p.delete();
      for (int i = 0; i < 50; i++) p.push_back(8'(8'h80 + i));
      send_frame(p, 1'b1, 0, -1, 29, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk("in-reset tx_ready", 32'(rdy), 32'd0);
      rst_n = 1'b1;
      lens.delete();
      chk_en = 1;
      repeat (2) @(negedge clk);
      #1;

      // 1-byte frame 0xAA after reset: full preamble, padded to 60
      p.delete();
      p.push_back(8'hAA);
      send_frame(p, 1'b1, 0, -1, -1, 1'b0);
      repeat (80) @(negedge clk);
      #1;
      chk("one-byte frame count", 32'(lens.size()), 32'd1);
      chk("one-byte valid run", 32'(lens[0]), 32'd72);
      chk("one-byte preamble", 32'(last_frame[0]), 32'h55);
      chk("one-byte payload", 32'(last_frame[8]), 32'hAA);
      chk("one-byte zero pad", 32'(count_zero(9, 67)), 32'd59);

      chk("model queue drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
